// File: rtl/m16_pkg.sv
// Shared constants, state encoding and serial-word sizing for the M16 word serializer.
// Honours M16_PARITY_EN: when defined, every serial word carries one extra odd-parity bit.
package m16_pkg;

   localparam int M16_WORD_W      = 12;
   localparam int M16_ADDR_W      = 11;
   localparam int M16_FRAME_WORDS = 2048;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      SHIFT = 2'd3
   } ser_state_t;

   // Bit periods per serial word for a given data width.
   function automatic int ser_bits(input int word_w);
`ifdef M16_PARITY_EN
      return word_w + 1;
`else
      return word_w;
`endif
   endfunction

endpackage

// File: rtl/m16_bit_timer.sv
// Bit-period divider and bit counter for the serializer; both stay cleared while run_i is low.
// Emits bit_tick on the last divider cycle, last_bit during the final bit, prefetch_pt on its first cycle.
module m16_bit_timer #(
   parameter int BIT_DIV = 4,
   parameter int SER_W   = 12
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   output logic bit_tick_o,
   output logic last_bit_o,
   output logic prefetch_pt_o
);

   localparam int DIV_W = $clog2(BIT_DIV);
   localparam int CNT_W = $clog2(SER_W);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] bit_q, bit_d;

   assign bit_tick_o    = run_i && (div_q == DIV_W'(BIT_DIV - 1));
   assign last_bit_o    = (bit_q == CNT_W'(SER_W - 1));
   assign prefetch_pt_o = run_i && last_bit_o && (div_q == '0);

   always_comb begin
      div_d = div_q;
      bit_d = bit_q;
      if (!run_i) begin
         div_d = '0;
         bit_d = '0;
      end else if (bit_tick_o) begin
         div_d = '0;
         bit_d = last_bit_o ? '0 : bit_q + CNT_W'(1);
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         bit_q <= '0;
      end else begin
         div_q <= div_d;
         bit_q <= bit_d;
      end
   end

endmodule

// File: rtl/m16_word_serializer.sv
// M16 word serializer: walks the frame buffer, fetches each word and shifts it out MSB-first without gaps.
// Define M16_PARITY_EN to append an odd-parity bit period after the data bits of every word.
module m16_word_serializer
   import m16_pkg::*;
#(
   parameter int WORD_W      = M16_WORD_W,
   parameter int ADDR_W      = M16_ADDR_W,
   parameter int FRAME_WORDS = M16_FRAME_WORDS,
   parameter int BIT_DIV     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [WORD_W-1:0] dataWord,
   output logic              bufGetWord,
   output logic [ADDR_W-1:0] bufRdPointer,
   output logic              serOut,
   output logic              serValid,
   output logic              wordStrobe,
   output logic              frameStart,
   output ser_state_t        dbg_state
);

   localparam int SER_W = ser_bits(WORD_W);

   if (BIT_DIV < 3) begin : g_bad_bit_div
      $error("m16_word_serializer: BIT_DIV must be >= 3");
   end

   ser_state_t        state_q;
   logic [ADDR_W-1:0] ptr_q, ptr_inc;
   logic [SER_W-1:0]  shreg_q, load_word;
   logic              req_q, valid_q, ws_q, fs_q;
   logic              bit_tick, last_bit, prefetch_pt, prefetch_go;

   m16_bit_timer #(
      .BIT_DIV (BIT_DIV),
      .SER_W   (SER_W)
   ) u_bit_timer (
      .clk           (clk),
      .reset         (reset),
      .run_i         (state_q == SHIFT),
      .bit_tick_o    (bit_tick),
      .last_bit_o    (last_bit),
      .prefetch_pt_o (prefetch_pt)
   );

   if (FRAME_WORDS == (1 << ADDR_W)) begin : g_ptr_natural
      assign ptr_inc = ptr_q + ADDR_W'(1);
   end else begin : g_ptr_compare
      assign ptr_inc = (ptr_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : ptr_q + ADDR_W'(1);
   end

`ifdef M16_PARITY_EN
   assign load_word = {dataWord, ~^dataWord};
`else
   assign load_word = dataWord;
`endif

   // The prefetch decision samples enable on the first cycle of the last bit period.
   assign prefetch_go  = prefetch_pt && enable;
   assign bufGetWord   = (state_q == FETCH) || prefetch_go;
   assign bufRdPointer = ptr_q;
   assign serOut       = shreg_q[SER_W-1];
   assign serValid     = valid_q;
   assign wordStrobe   = ws_q;
   assign frameStart   = fs_q;
   assign dbg_state    = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         shreg_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         ws_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         ws_q <= 1'b0;
         fs_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) state_q <= FETCH;
            end
            FETCH: begin
               state_q <= WAIT;
            end
            WAIT: begin
               state_q <= SHIFT;
               shreg_q <= load_word;
               valid_q <= 1'b1;
               ws_q    <= 1'b1;
               fs_q    <= (ptr_q == '0);
               ptr_q   <= ptr_inc;
            end
            SHIFT: begin
               if (prefetch_go) req_q <= 1'b1;
               if (bit_tick) begin
                  if (last_bit) begin
                     req_q <= 1'b0;
                     if (req_q) begin
                        shreg_q <= load_word;
                        ws_q    <= 1'b1;
                        fs_q    <= (ptr_q == '0);
                        ptr_q   <= ptr_inc;
                     end else begin
                        state_q <= IDLE;
                        shreg_q <= '0;
                        valid_q <= 1'b0;
                     end
                  end else begin
                     shreg_q <= shreg_q << 1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m16_word_serializer.sv
// Bench for m16_word_serializer: randomized frame data and enable patterns against a word-level timeline model.
// Compile with M16_PARITY_EN defined to also exercise the parity bit.
module tb_m16_word_serializer;
   import m16_pkg::*;

   localparam int WORD_W = 12;
   localparam int BD     = 4;
   localparam int N      = 2048;
`ifdef M16_PARITY_EN
   localparam int SER_W = WORD_W + 1;
`else
   localparam int SER_W = WORD_W;
`endif
   localparam int P    = SER_W * BD;
   localparam int PF   = (SER_W - 1) * BD;
   localparam int MAXT = 1100;

   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, en_w = 1'b0;
   logic [11:0] data_word = '0, data8 = '0, data6 = '0;
   logic        buf_get, ser_out, ser_valid, word_strobe, frame_start;
   logic [10:0] rd_ptr;
   logic        get8, out8, val8, ws8, fs8, get6, out6, val6, ws6, fs6;
   logic [2:0]  ptr8, ptr6;
   ser_state_t  dbg_state, st8, st6;

   logic [11:0] mem [N];
   bit          en_s [MAXT];
   logic [15:0] exp_v [MAXT];
   logic [15:0] obs_v [MAXT];
   int          tests_run = 0, tests_failed = 0;

   always #5 clk = ~clk;

   m16_word_serializer dut (
      .clk(clk), .reset(reset), .enable(enable), .dataWord(data_word),
      .bufGetWord(buf_get), .bufRdPointer(rd_ptr), .serOut(ser_out), .serValid(ser_valid),
      .wordStrobe(word_strobe), .frameStart(frame_start), .dbg_state(dbg_state)
   );

   m16_word_serializer #(.ADDR_W(3), .FRAME_WORDS(8)) dut8 (
      .clk(clk), .reset(reset), .enable(en_w), .dataWord(data8),
      .bufGetWord(get8), .bufRdPointer(ptr8), .serOut(out8), .serValid(val8),
      .wordStrobe(ws8), .frameStart(fs8), .dbg_state(st8)
   );

   m16_word_serializer #(.ADDR_W(3), .FRAME_WORDS(6)) dut6 (
      .clk(clk), .reset(reset), .enable(en_w), .dataWord(data6),
      .bufGetWord(get6), .bufRdPointer(ptr6), .serOut(out6), .serValid(val6),
      .wordStrobe(ws6), .frameStart(fs6), .dbg_state(st6)
   );

   // Filler model: registers the addressed word one edge after it sees a request.
   always @(posedge clk) begin
      if (buf_get) data_word <= mem[rd_ptr];
      if (get8)    data8     <= mem[ptr8];
      if (get6)    data6     <= mem[ptr6];
   end

   function automatic logic bit_of(input logic [11:0] w, input int b);
      if (b < WORD_W) return w[WORD_W-1-b];
      return ~^w;
   endfunction

   task automatic fill_en(input int lo, input int hi, input bit v);
      for (int i = lo; i < hi && i < MAXT; i++) en_s[i] = v;
   endtask

   // Word-level timeline: {get, ptr[10:0], valid, out, strobe, frame} per cycle from the enable schedule.
   task automatic build_model(input int p0, input int t_len);
      int t, s, q, ptr;
      logic [11:0] w;
      for (int i = 0; i < t_len; i++) exp_v[i] = {1'b0, 11'(p0), 4'b0000};
      ptr = p0;
      t = 0;
      while (t < t_len) begin
         if (!en_s[t]) begin
            t++;
         end else begin
            if (t + 1 < t_len) exp_v[t+1][15] = 1'b1;
            s = t + 3;
            q = 0;
            while (q >= 0) begin
               w = mem[ptr];
               if (s < t_len) begin
                  exp_v[s][1] = 1'b1;
                  exp_v[s][0] = (ptr == 0);
               end
               ptr = (ptr + 1) % N;
               for (int i = s; i < t_len; i++) exp_v[i][14:4] = 11'(ptr);
               for (int i = 0; i < P; i++) begin
                  if (s + i < t_len) begin
                     exp_v[s+i][3] = 1'b1;
                     exp_v[s+i][2] = bit_of(w, i / BD);
                  end
               end
               q = s + PF;
               if (q < t_len && en_s[q]) begin
                  exp_v[q][15] = 1'b1;
                  s += P;
               end else begin
                  q = -1;
               end
            end
            t = s + P;
         end
      end
   endtask

   task automatic run_window(input int t_len);
      for (int t = 0; t < t_len; t++) begin
         @(posedge clk); #1;
         enable = en_s[t];
         @(negedge clk);
         obs_v[t] = {buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start};
      end
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      en_w   = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start} !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 0000", {buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start});
      end
      tests_run++;
      if (dbg_state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      tests_run++;
      if ({get8, ptr8, val8, out8, get6, ptr6, val6, out6} !== 12'h0) begin
         tests_failed++;
         $display("FAIL reset_small_outputs: got %h expected 000", {get8, ptr8, val8, out8, get6, ptr6, val6, out6});
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++;
      if ({buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start} !== 16'h0 || dbg_state !== IDLE) begin
         tests_failed++;
         $display("FAIL idle_disabled: got %h state %0d expected 0000 state %0d",
                  {buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start}, dbg_state, IDLE);
      end
   endtask

   task automatic test_first_word();
      int t_len;
      logic [11:0] got_w;
      bit stable;
      mem[0] = 12'h5A3;
      do_reset();
      fill_en(0, MAXT, 1'b1);
      t_len = 3 + P + 4;
      build_model(0, t_len);
      run_window(t_len);
      for (int t = 0; t < t_len; t++) begin
         tests_run++;
         if (obs_v[t] !== exp_v[t]) begin
            tests_failed++;
            $display("FAIL first_word cycle %0d: got %h expected %h (get,ptr,val,out,ws,fs)", t, obs_v[t], exp_v[t]);
            break;
         end
      end
      tests_run++;
      if (obs_v[1][15:4] !== 12'h800 || obs_v[0][15] !== 1'b0 || obs_v[2][15] !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_fetch: got c0=%b c1=%b ptr=%0d c2=%b expected c0=0 c1=1 ptr=0 c2=0",
                  obs_v[0][15], obs_v[1][15], obs_v[1][14:4], obs_v[2][15]);
      end
      tests_run++;
      if (obs_v[2][3] !== 1'b0 || obs_v[3][3] !== 1'b1 || obs_v[3][1:0] !== 2'b11 || obs_v[4][1:0] !== 2'b00) begin
         tests_failed++;
         $display("FAIL first_valid_strobes: got val2=%b val3=%b ws/fs3=%b ws/fs4=%b expected 0 1 11 00",
                  obs_v[2][3], obs_v[3][3], obs_v[3][1:0], obs_v[4][1:0]);
      end
      stable = 1'b1;
      for (int b = 0; b < WORD_W; b++) begin
         got_w[WORD_W-1-b] = obs_v[3 + b*BD][2];
         for (int d = 1; d < BD; d++) if (obs_v[3 + b*BD + d][2] !== obs_v[3 + b*BD][2]) stable = 1'b0;
      end
      tests_run++;
      if (got_w !== 12'h5A3 || !stable) begin
         tests_failed++;
         $display("FAIL first_word_bits: got %h stable=%b expected 5a3 stable=1", got_w, stable);
      end
   endtask

   task automatic test_continuous();
      int t_len, prev_ws, gap_at;
      do_reset();
      fill_en(0, MAXT, 1'b1);
      t_len = 3 + 3*P + 8;
      build_model(0, t_len);
      run_window(t_len);
      for (int t = 0; t < t_len; t++) begin
         tests_run++;
         if (obs_v[t] !== exp_v[t]) begin
            tests_failed++;
            $display("FAIL continuous cycle %0d: got %h expected %h (get,ptr,val,out,ws,fs)", t, obs_v[t], exp_v[t]);
            break;
         end
      end
      prev_ws = -1;
      gap_at  = -1;
      for (int t = 1; t < t_len; t++) begin
         if (obs_v[t][15] && t > 1) begin
            tests_run++;
            if (obs_v[t-1][15] || ((t - 3) % P) != PF) begin
               tests_failed++;
               $display("FAIL prefetch_slot cycle %0d: got offset %0d prev_get=%b expected offset %0d prev_get=0",
                        t, (t - 3) % P, obs_v[t-1][15], PF);
            end
         end
         if (obs_v[t][1]) begin
            if (prev_ws >= 0) begin
               tests_run++;
               if (t - prev_ws != P) begin
                  tests_failed++;
                  $display("FAIL strobe_period: got %0d expected %0d", t - prev_ws, P);
               end
            end
            prev_ws = t;
         end
         if (t >= 3 && !obs_v[t][3] && gap_at < 0) gap_at = t;
      end
      tests_run++;
      if (gap_at != -1) begin
         tests_failed++;
         $display("FAIL no_valid_gap: got gap at cycle %0d expected none", gap_at);
      end
   endtask

   task automatic test_stop_resume();
      int stop_at, resume_at, idle_at, t_len, first_get;
      do_reset();
      stop_at   = 3 + 5*P + P/2;
      resume_at = 3 + 6*P + 30;
      idle_at   = 3 + 6*P;
      t_len     = resume_at + 3 + P + 10;
      fill_en(0, MAXT, 1'b1);
      fill_en(stop_at, resume_at, 1'b0);
      build_model(0, t_len);
      run_window(t_len);
      for (int t = 0; t < t_len; t++) begin
         tests_run++;
         if (obs_v[t] !== exp_v[t]) begin
            tests_failed++;
            $display("FAIL stop_resume cycle %0d: got %h expected %h (get,ptr,val,out,ws,fs)", t, obs_v[t], exp_v[t]);
            break;
         end
      end
      for (int t = idle_at; t <= resume_at; t++) begin
         tests_run++;
         if ({obs_v[t][15], obs_v[t][3:2]} !== 3'b000 || obs_v[t][14:4] !== 11'd6) begin
            tests_failed++;
            $display("FAIL stopped_idle cycle %0d: got get/val/out=%b ptr=%0d expected 000 ptr=6",
                     t, {obs_v[t][15], obs_v[t][3:2]}, obs_v[t][14:4]);
            break;
         end
      end
      first_get = -1;
      for (int t = stop_at; t < t_len && first_get < 0; t++) if (obs_v[t][15]) first_get = t;
      tests_run++;
      if (first_get != resume_at + 1 || obs_v[resume_at + 1][14:4] !== 11'd6) begin
         tests_failed++;
         $display("FAIL resume_fetch: got cycle %0d ptr %0d expected cycle %0d ptr 6",
                  first_get, obs_v[resume_at + 1][14:4], resume_at + 1);
      end
   endtask

   task automatic test_random_enable();
      int t_len, t, seg;
      bit v;
      do_reset();
      t_len = 1000;
      t = 0;
      v = 1'b1;
      while (t < t_len) begin
         seg = $urandom_range(5, 120);
         fill_en(t, t + seg, v);
         t += seg;
         v = ~v;
      end
      build_model(0, t_len);
      run_window(t_len);
      for (int i = 0; i < t_len; i++) begin
         tests_run++;
         if (obs_v[i] !== exp_v[i]) begin
            tests_failed++;
            $display("FAIL random_enable cycle %0d: got %h expected %h (get,ptr,val,out,ws,fs)", i, obs_v[i], exp_v[i]);
            break;
         end
      end
   endtask

   task automatic test_reset_midword();
      logic [11:0] saved;
      int t_len;
      saved  = mem[0];
      mem[0] = 12'hFFF;
      do_reset();
      fill_en(0, MAXT, 1'b1);
      run_window(3 + 7*BD + 2);
      #2;
      tests_run++;
      if ({ser_valid, ser_out} !== 2'b11) begin
         tests_failed++;
         $display("FAIL midword_before_reset: got val/out=%b expected 11", {ser_valid, ser_out});
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if ({buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start} !== 16'h0 || dbg_state !== IDLE) begin
         tests_failed++;
         $display("FAIL async_reset: got %h state %0d expected 0000 state %0d",
                  {buf_get, rd_ptr, ser_valid, ser_out, word_strobe, frame_start}, dbg_state, IDLE);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      t_len = 3 + P + 4;
      build_model(0, t_len);
      run_window(t_len);
      for (int t = 0; t < t_len; t++) begin
         tests_run++;
         if (obs_v[t] !== exp_v[t]) begin
            tests_failed++;
            $display("FAIL reset_restart cycle %0d: got %h expected %h (get,ptr,val,out,ws,fs)", t, obs_v[t], exp_v[t]);
            break;
         end
      end
      mem[0] = saved;
   endtask

   task automatic test_wrap();
      int k8, k6, n8, n6, f8, f6, last8, last6, t_len, nw;
      k8 = 0; k6 = 0; n8 = 0; n6 = 0; f8 = 0; f6 = 0; last8 = -1; last6 = -1;
      t_len = 25 * P;
      do_reset();
      @(posedge clk); #1;
      en_w = 1'b1;
      for (int t = 0; t < t_len; t++) begin
         @(negedge clk);
         if (get8) begin
            tests_run++;
            if (ptr8 !== 3'(k8 % 8)) begin
               tests_failed++;
               $display("FAIL wrap8_fetch_ptr #%0d: got %0d expected %0d", k8, ptr8, k8 % 8);
            end
            k8++;
         end
         if (get6) begin
            tests_run++;
            if (ptr6 !== 3'(k6 % 6)) begin
               tests_failed++;
               $display("FAIL wrap6_fetch_ptr #%0d: got %0d expected %0d", k6, ptr6, k6 % 6);
            end
            k6++;
         end
         if (ws8) begin
            tests_run++;
            if (fs8 !== (n8 % 8 == 0) || (fs8 && last8 >= 0 && t - last8 != 8*P)) begin
               tests_failed++;
               $display("FAIL wrap8_frame word %0d: got fs=%b period=%0d expected fs=%b period=%0d",
                        n8, fs8, t - last8, (n8 % 8 == 0), 8*P);
            end
            if (fs8) begin f8++; last8 = t; end
            n8++;
         end
         if (ws6) begin
            tests_run++;
            if (fs6 !== (n6 % 6 == 0) || (fs6 && last6 >= 0 && t - last6 != 6*P)) begin
               tests_failed++;
               $display("FAIL wrap6_frame word %0d: got fs=%b period=%0d expected fs=%b period=%0d",
                        n6, fs6, t - last6, (n6 % 6 == 0), 6*P);
            end
            if (fs6) begin f6++; last6 = t; end
            n6++;
         end
      end
      en_w = 1'b0;
      nw = (t_len - 4) / P + 1;
      tests_run++;
      if (n8 != nw || f8 != (nw + 7) / 8 || n6 != nw || f6 != (nw + 5) / 6) begin
         tests_failed++;
         $display("FAIL wrap_counts: got words %0d/%0d frames %0d/%0d expected words %0d frames %0d/%0d",
                  n8, n6, f8, f6, nw, (nw + 7) / 8, (nw + 5) / 6);
      end
   endtask

`ifdef M16_PARITY_EN
   task automatic test_parity();
      logic [11:0] saved;
      int t_len;
      saved  = mem[0];
      mem[0] = 12'h001;
      do_reset();
      fill_en(0, MAXT, 1'b1);
      t_len = 3 + 2*P + 2;
      build_model(0, t_len);
      run_window(t_len);
      for (int t = 0; t < t_len; t++) begin
         tests_run++;
         if (obs_v[t] !== exp_v[t]) begin
            tests_failed++;
            $display("FAIL parity_stream cycle %0d: got %h expected %h (get,ptr,val,out,ws,fs)", t, obs_v[t], exp_v[t]);
            break;
         end
      end
      tests_run++;
      if (obs_v[3 + 44][3:2] !== 2'b11 || obs_v[3 + 48][3:2] !== 2'b10 || obs_v[3 + 51][3:2] !== 2'b10) begin
         tests_failed++;
         $display("FAIL parity_bit: got lsb=%b par=%b par_end=%b expected 11 10 10",
                  obs_v[3 + 44][3:2], obs_v[3 + 48][3:2], obs_v[3 + 51][3:2]);
      end
      tests_run++;
      if (obs_v[3 + 48][1] !== 1'b0 || obs_v[3 + 52][1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL parity_period: got ws48=%b ws52=%b expected 0 1", obs_v[3 + 48][1], obs_v[3 + 52][1]);
      end
      mem[0] = saved;
   endtask
`endif

   initial begin
      for (int i = 0; i < N; i++) mem[i] = 12'($urandom);
      test_reset();
      test_first_word();
      test_continuous();
      test_stop_resume();
      test_random_enable();
      test_reset_midword();
      test_wrap();
`ifdef M16_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
